// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM state, read-return owner,
// and the default starvation limit.
package dmem_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        CPU  = 2'b01,
        DBG  = 2'b10
    } owner_t;

    localparam int STARVE_LIM_DEF = 4;
    // Counter wide enough for the full 1..15 limit range.
    localparam int CNT_W          = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-way arbiter for the single-port data memory: the CPU has fixed priority,
// the debug port has a starvation guard and an exclusive lock.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk_arb,
    input  logic              rstn_arb,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_lock,
    output logic              lock_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    arb_state_t       state_q, state_d;
    owner_t           rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Grants are forced low while reset is held so nothing reaches memory.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rstn_arb) begin
            if (state_q == LOCK) begin
                dbg_gnt = dbg_req;
            end else if (cpu_req && dbg_req) begin
                if (starve_cnt_q == LIM) dbg_gnt = 1'b1;
                else                     cpu_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_we    = dbg_we;
            mem_wdata = dbg_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        rd_owner_d   = NONE;

        case (state_q)
            ARB:     if (dbg_lock)  state_d = LOCK;
            LOCK:    if (!dbg_lock) state_d = ARB;
            default: state_d = ARB;
        endcase

        // Only a contested CPU win advances the guard; it saturates at the limit.
        if (state_q == LOCK || dbg_gnt || !dbg_req)
            starve_cnt_d = '0;
        else if (cpu_gnt && starve_cnt_q < LIM)
            starve_cnt_d = starve_cnt_q + 1'b1;

        if (cpu_gnt && !cpu_we)
            rd_owner_d = CPU;
        else if (dbg_gnt && !dbg_we)
            rd_owner_d = DBG;
    end

    always_ff @(posedge clk_arb or negedge rstn_arb) begin
        if (!rstn_arb) begin
            state_q      <= ARB;
            starve_cnt_q <= '0;
            rd_owner_q   <= NONE;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Read data is steered to whoever issued the read one cycle earlier.
    assign cpu_rvalid = (rd_owner_q == CPU);
    assign dbg_rvalid = (rd_owner_q == DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    assign lock_ack   = (state_q == LOCK);
    assign cpu_stall  = cpu_req & ~cpu_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected read data goes into per-port queues
// at issue time and a negedge monitor checks every rvalid against them.
module tb_dmem_arbiter;

    logic       clk_arb = 1'b0;
    logic       rstn_arb;
    logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [3:0] cpu_addr, dbg_addr;
    logic [7:0] cpu_wdata, dbg_wdata;
    logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, lock_ack, mem_we, cpu_stall;
    logic [7:0] cpu_rdata, dbg_rdata, mem_wdata;
    logic [7:0] mem_rdata;
    logic [3:0] mem_addr;
    logic       preload;

    logic [7:0] mem [16];
    logic [7:0] cpu_q[$];
    logic [7:0] dbg_q[$];
    int         vectors = 0;
    int         errors  = 0;

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .STARVE_LIM(4)) dut (
        .clk_arb(clk_arb), .rstn_arb(rstn_arb),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_lock(dbg_lock), .lock_ack(lock_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall)
    );

    always #5 clk_arb = ~clk_arb;

    // Synchronous-read 16x8 memory; preload puts known words at addresses 1, 2, 3.
    always @(posedge clk_arb) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            mem[1] <= 8'h3C;
            mem[2] <= 8'hC3;
            mem[3] <= 8'h5A;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic cr, input logic cw, input logic [3:0] ca, input logic [7:0] cd,
                          input logic dr, input logic dw, input logic [3:0] da, input logic [7:0] dd,
                          input logic lk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        dbg_lock = lk;
    endtask

    task automatic next_cycle();
        @(posedge clk_arb);
        #1;
    endtask

    // Scoreboard monitor: each rvalid pops the owner's queue; non-owner rdata must be 0.
    always @(negedge clk_arb) begin
        if (rstn_arb === 1'b1) begin
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
                else chk("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, cpu_q.pop_front()});
                chk("dbg_rdata_idle", {31'h0, dbg_rvalid, dbg_rdata}, 0);
            end
            if (dbg_rvalid) begin
                if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", 1, 0);
                else chk("dbg_rdata", {24'h0, dbg_rdata}, {24'h0, dbg_q.pop_front()});
                chk("cpu_rdata_idle", {23'h0, cpu_rvalid, cpu_rdata}, 0);
            end
        end
    end

    // Expected CPU grant pattern under continuous contention with limit 4.
    logic [9:0] starve_pat;

    initial begin
        starve_pat = 10'b1111011110;
        rstn_arb = 1'b0;
        preload  = 1'b1;
        set_in(1'b1, 1'b1, 4'h5, 8'hEE, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);

        // Held in reset: requests must not reach memory.
        @(negedge clk_arb);
        chk("in_reset_outs", {cpu_gnt, dbg_gnt, mem_we, mem_addr, mem_wdata, lock_ack, cpu_rvalid},
            {1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0});
        next_cycle();
        next_cycle();
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        rstn_arb = 1'b1;
        preload  = 1'b0;

        @(negedge clk_arb);
        chk("reset_idle", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, lock_ack, cpu_stall, mem_we,
                           mem_addr, mem_wdata, cpu_rdata, dbg_rdata}, 0);
        next_cycle();

        // CPU read of address 3, debug idle.
        set_in(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        @(negedge clk_arb);
        chk("cpu_rd_gnt", {cpu_gnt, dbg_gnt, cpu_stall, mem_we, mem_addr}, {1'b1, 1'b0, 1'b0, 1'b0, 4'h3});
        cpu_q.push_back(8'h5A);
        next_cycle();
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        next_cycle();

        // Continuous contention: CPU reads addr 1, debug reads addr 2.
        set_in(1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00, 1'b0);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk_arb);
            chk($sformatf("starve_gnt_%0d", 9 - i), {cpu_gnt, dbg_gnt, cpu_stall},
                {starve_pat[i], ~starve_pat[i], ~starve_pat[i]});
            if (starve_pat[i]) cpu_q.push_back(8'h3C);
            else               dbg_q.push_back(8'hC3);
            next_cycle();
        end
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        next_cycle();

        // Debug write 0xA5 to addr 7, then CPU reads it back.
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h7, 8'hA5, 1'b0);
        @(negedge clk_arb);
        chk("dbg_wr", {dbg_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b0, 1'b1, 4'h7, 8'hA5});
        next_cycle();
        set_in(1'b1, 1'b0, 4'h7, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        @(negedge clk_arb);
        chk("cpu_rd7_gnt", {cpu_gnt, mem_we, mem_addr}, {1'b1, 1'b0, 4'h7});
        cpu_q.push_back(8'hA5);
        next_cycle();

        // Lock entry with a CPU read in flight.
        set_in(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        @(negedge clk_arb);
        chk("lock_entry", {cpu_gnt, dbg_gnt, cpu_stall, lock_ack}, 4'b1000);
        cpu_q.push_back(8'h5A);
        next_cycle();
        set_in(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h0, 8'h11, 1'b1);
        @(negedge clk_arb);
        chk("lock_dbg_wr", {cpu_gnt, dbg_gnt, cpu_stall, lock_ack, mem_we, mem_addr, mem_wdata},
            {4'b0111, 1'b1, 4'h0, 8'h11});
        next_cycle();
        set_in(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        @(negedge clk_arb);
        chk("lock_cpu_stall", {cpu_gnt, dbg_gnt, cpu_stall, lock_ack, mem_we}, 5'b00110);
        next_cycle();
        @(negedge clk_arb);
        chk("unlock_cpu_gnt", {cpu_gnt, dbg_gnt, cpu_stall, lock_ack, mem_addr}, {4'b1000, 4'h0});
        cpu_q.push_back(8'h11);
        next_cycle();
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        next_cycle();

        // Lock rises together with both requests: CPU still wins this cycle.
        set_in(1'b1, 1'b0, 4'h7, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00, 1'b1);
        @(negedge clk_arb);
        chk("lock_race", {cpu_gnt, dbg_gnt, cpu_stall, lock_ack}, 4'b1000);
        cpu_q.push_back(8'hA5);
        next_cycle();
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00, 1'b1);
        @(negedge clk_arb);
        chk("lock_race_dbg", {cpu_gnt, dbg_gnt, lock_ack, mem_addr}, {3'b011, 4'h3});
        dbg_q.push_back(8'h5A);
        next_cycle();
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);

        // Asynchronous reset while debug read data is being returned, writes pending.
        @(negedge clk_arb);
        #2;
        rstn_arb = 1'b0;
        set_in(1'b1, 1'b1, 4'h5, 8'hFF, 1'b1, 1'b1, 4'h5, 8'hFF, 1'b1);
        #1;
        chk("async_rst", {dbg_rvalid, cpu_rvalid, lock_ack, cpu_gnt, dbg_gnt, mem_we, mem_addr, mem_wdata, dbg_rdata},
            0);
        next_cycle();
        next_cycle();
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        rstn_arb = 1'b1;

        // Address 5 must still hold 0 after the reset window.
        set_in(1'b1, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        @(negedge clk_arb);
        chk("post_rst_gnt", {cpu_gnt, lock_ack, cpu_stall}, 3'b100);
        cpu_q.push_back(8'h00);
        next_cycle();
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) next_cycle();

        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("dbg_q_drained", dbg_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16x8 data memory between two requesters: the CPU control unit and a debug/host loader port.
- Arbitration is combinational and single-cycle. Fixed priority favours the CPU, with a starvation guard for the debug port.
- The debug port can take an exclusive lock, so it can inspect or patch memory while the CPU stalls.
- Sits between the control unit's memory command signals and the data memory inside the datapath.

Parameters:
- ADDR_W, 4, data memory address width
- DATA_W, 8, data word width
- STARVE_LIM, 4, number of consecutive contested CPU wins after which the debug port wins once (range 1..15)

Ports:
- clk_arb  in  1  system clock, rising edge
- rstn_arb  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU command valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  command accepted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req  in  1  debug command valid
- dbg_we  in  1  debug write enable
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug command accepted (combinational)
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_W  debug read data
- dbg_lock  in  1  debug requests exclusive memory ownership
- lock_ack  out  1  exclusive lock active
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the address is sampled
- cpu_stall  out  1  cpu_req & ~cpu_gnt

Behaviour:
- One clock. Reset is asynchronous, active-low.
- Reset values:
  - state = ARB
  - starve_cnt = 0
  - cpu_rvalid = dbg_rvalid = 0
  - lock_ack = 0
  - rd_owner = NONE
- Combinational outputs while reset is asserted: all gnt = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0.
- Transfer rule: a transfer occurs at a rising edge when req & gnt. The requester holds req and its command stable until it sees gnt.
  - Back-to-back transfers are allowed, one per cycle.
  - A requester may drop req at any time before gnt is seen.
- mem_* signals are muxed combinationally from the granted requester.
  - With no grant: mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - mem_we is never high without a gnt.
- Read latency is 1 cycle. A read transfer at edge N gives owner rvalid = 1 for cycle N+1, with owner rdata = mem_rdata.
  - The non-owner's rdata is 0.
  - rvalid is a one-cycle pulse per read.
  - Writes produce no rvalid.
- State ARB:
  - Only cpu_req: cpu wins.
  - Only dbg_req: dbg wins.
  - Both, starve_cnt < STARVE_LIM: cpu wins, starve_cnt += 1 at the edge.
  - Both, starve_cnt == STARVE_LIM: dbg wins.
  - starve_cnt clears to 0 at any edge where dbg is granted or dbg_req = 0.
  - starve_cnt saturates at STARVE_LIM and never wraps.
- State LOCK:
  - cpu_gnt = 0.
  - dbg_gnt = dbg_req.
  - starve_cnt is held at 0.
  - lock_ack = 1.
- Transitions, evaluated at the edge:
  - ARB -> LOCK when dbg_lock = 1. The current cycle's grant still completes.
  - LOCK -> ARB when dbg_lock = 0.
  - lock_ack is registered, so it equals (state == LOCK).
- Read straddling lock entry: a CPU read granted in the last ARB cycle still returns cpu_rvalid in the first LOCK cycle.
- Reset mid-operation: pending rvalid is dropped, the lock is released, and the counter is cleared. No memory write occurs while rstn_arb = 0.
- Same-address write then read in consecutive cycles is ordered by grant order. The arbiter adds no reordering or buffering.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding (ARB = 1'b0, LOCK = 1'b1)
  - owner encoding (NONE = 2'b00, CPU = 2'b01, DBG = 2'b10)
  - default STARVE_LIM
- Single module. No sub-module is needed; the starvation counter is a few lines.

Test Plan:
- After reset release with no requests -> all outputs 0 and mem_we = 0. Assert rstn_arb low asynchronously mid-read -> cpu_rvalid drops immediately.
- cpu read addr 3 with mem[3] = 0x5A, dbg idle -> cpu_gnt same cycle; cpu_rvalid = 1, cpu_rdata = 0x5A next cycle; dbg_rdata = 0.
- Both requesting continuously, STARVE_LIM = 4 -> grant pattern C,C,C,C,D,C,C,C,C,D. cpu_stall = 1 exactly in the D cycles.
- dbg write 0xA5 to addr 7 while CPU idle, then cpu read addr 7 the next cycle -> cpu_rdata = 0xA5.
- dbg_lock = 1 while CPU streams reads -> in-flight CPU read still returns; lock_ack = 1 from next cycle; cpu_gnt = 0 and cpu_stall = 1 throughout LOCK; dbg writes 0x11 to addr 0.
  - Then drop dbg_lock -> back to ARB next cycle, CPU granted, cpu read addr 0 returns 0x11.
- Simultaneous dbg_lock rise and both requests in the same cycle -> cpu wins that cycle, and LOCK starts next cycle.
